// File: rtl/noc_pkg.sv
// Shared NoC router types: port index width, port directions and the
// per-output allocator state used by switch_allocator.
package noc_pkg;

  localparam int PORT_NUM = 5;
  localparam int PORT_W   = 3;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 0,
    NORTH,
    EAST,
    SOUTH,
    WEST
  } port_e;

  typedef enum logic {
    IDLE,
    BUSY
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo N. Produces a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic found;

  // Two linear passes (upper segment from ptr, then from 0) replace a modulo search.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-router switch allocator: one wormhole-locked round-robin arbiter per output.
// Optional SWA_PERF_CNT_EN adds saturating per-output grant and per-input stall counters.
module switch_allocator #(
  parameter int IN_NUM  = 5,
  parameter int OUT_NUM = 5,
  parameter int PORT_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_NUM-1:0]         req,
  input  logic [IN_NUM*PORT_W-1:0]  dest,
  output logic [IN_NUM-1:0]         grant,
  output logic [OUT_NUM*PORT_W-1:0] xbar_sel,
  output logic [OUT_NUM-1:0]        out_busy,
  output logic [IN_NUM-1:0]         dest_err
`ifdef SWA_PERF_CNT_EN
  ,
  output logic [OUT_NUM*16-1:0]     grant_cnt,
  output logic [IN_NUM*16-1:0]      stall_cnt
`endif
);

  import noc_pkg::*;

  out_state_e        state_q [OUT_NUM];
  out_state_e        state_n [OUT_NUM];
  logic [PORT_W-1:0] owner_q [OUT_NUM];
  logic [PORT_W-1:0] owner_n [OUT_NUM];
  logic [PORT_W-1:0] ptr_q   [OUT_NUM];
  logic [PORT_W-1:0] ptr_n   [OUT_NUM];
  logic [PORT_W-1:0] arb_idx [OUT_NUM];
  logic [IN_NUM-1:0] elig    [OUT_NUM];
  logic [IN_NUM-1:0] arb_gnt [OUT_NUM];
  logic [IN_NUM-1:0] grant_n;
  logic [IN_NUM-1:0] err_n;

  // Already-granted inputs are excluded everywhere, which also blocks a
  // released owner from re-winning on its release edge.
  always_comb begin
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      elig[o] = '0;
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        elig[o][i] = req[i] && !grant[i] &&
                     (dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
    end
    for (int unsigned i = 0; i < IN_NUM; i++) begin
      err_n[i] = req[i] && (32'(dest[i*PORT_W +: PORT_W]) >= OUT_NUM);
    end
  end

  for (genvar o = 0; o < OUT_NUM; o++) begin : g_out
    rr_arbiter #(
      .N(IN_NUM),
      .W(PORT_W)
    ) u_arb (
      .req(elig[o]),
      .ptr(ptr_q[o]),
      .gnt(arb_gnt[o]),
      .idx(arb_idx[o])
    );
  end

  always_comb begin
    grant_n = '0;
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      state_n[o] = state_q[o];
      owner_n[o] = owner_q[o];
      ptr_n[o]   = ptr_q[o];
      case (state_q[o])
        IDLE: begin
          if (|arb_gnt[o]) begin
            state_n[o] = BUSY;
            owner_n[o] = arb_idx[o];
            ptr_n[o]   = (arb_idx[o] == PORT_W'(IN_NUM - 1)) ? '0
                                                             : arb_idx[o] + PORT_W'(1);
          end
        end
        BUSY: begin
          if (!req[owner_q[o]]) state_n[o] = IDLE;
        end
        default: state_n[o] = IDLE;
      endcase
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        if ((state_n[o] == BUSY) && (owner_n[o] == PORT_W'(i))) grant_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant    <= '0;
      dest_err <= '0;
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      grant    <= grant_n;
      dest_err <= err_n;
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        state_q[o] <= state_n[o];
        owner_q[o] <= owner_n[o];
        ptr_q[o]   <= ptr_n[o];
      end
    end
  end

  always_comb begin
    xbar_sel = '0;
    out_busy = '0;
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      xbar_sel[o*PORT_W +: PORT_W] = owner_q[o];
      out_busy[o]                  = (state_q[o] == BUSY);
    end
  end

`ifdef SWA_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        if ((state_q[o] == IDLE) && (state_n[o] == BUSY) && (grant_cnt[o*16 +: 16] != 16'hFFFF))
          grant_cnt[o*16 +: 16] <= grant_cnt[o*16 +: 16] + 16'd1;
      end
      for (int unsigned i = 0; i < IN_NUM; i++) begin
        if (req[i] && !grant[i] && (stall_cnt[i*16 +: 16] != 16'hFFFF))
          stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator (default build, 5x5 ports).
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] dest;
  logic [4:0]  grant;
  logic [14:0] xbar_sel;
  logic [4:0]  out_busy;
  logic [4:0]  dest_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  switch_allocator #(
    .IN_NUM(5),
    .OUT_NUM(5),
    .PORT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .dest(dest),
    .grant(grant),
    .xbar_sel(xbar_sel),
    .out_busy(out_busy),
    .dest_err(dest_err)
  );

  task automatic set_dest(input int i, input logic [2:0] v);
    dest[i*3 +: 3] = v;
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    req  = '0;
    dest = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL reset_grant: got %b exp %b", grant, 5'b0); end
    tests++; if (xbar_sel !== 15'b0) begin fails++; $display("FAIL reset_xbar: got %b exp %b", xbar_sel, 15'b0); end
    tests++; if (out_busy !== 5'b0) begin fails++; $display("FAIL reset_busy: got %b exp %b", out_busy, 5'b0); end
    tests++; if (dest_err !== 5'b0) begin fails++; $display("FAIL reset_err: got %b exp %b", dest_err, 5'b0); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    req[0] = 1'b1; set_dest(0, 3'd2);
    #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL single_early: got %b exp %b", grant, 5'b0); end
    @(posedge clk); #1;
    tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL single_grant: got %b exp %b", grant, 5'b00001); end
    tests++; if (xbar_sel[8:6] !== 3'd0) begin fails++; $display("FAIL single_xbar: got %0d exp 0", xbar_sel[8:6]); end
    tests++; if (out_busy !== 5'b00100) begin fails++; $display("FAIL single_busy: got %b exp %b", out_busy, 5'b00100); end
    @(negedge clk);
    req[0] = 1'b0;
    @(posedge clk); #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL single_release_grant: got %b exp %b", grant, 5'b0); end
    tests++; if (out_busy !== 5'b0) begin fails++; $display("FAIL single_release_busy: got %b exp %b", out_busy, 5'b0); end
  endtask

  task automatic test_round_robin;
    int order [4] = '{1, 3, 4, 1};
    @(negedge clk);
    req[1] = 1'b1; set_dest(1, 3'd0);
    req[3] = 1'b1; set_dest(3, 3'd0);
    req[4] = 1'b1; set_dest(4, 3'd0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        tests++;
        if (grant !== (5'(1) << order[r])) begin
          fails++; $display("FAIL rr_owner r%0d c%0d: got %b exp %b", r, c, grant, 5'(1) << order[r]);
        end
        if (c == 0) begin
          tests++;
          if (xbar_sel[2:0] !== 3'(order[r])) begin
            fails++; $display("FAIL rr_xbar r%0d: got %0d exp %0d", r, xbar_sel[2:0], order[r]);
          end
        end
      end
      @(negedge clk);
      req[order[r]] = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ((grant !== 5'b0) || (out_busy[0] !== 1'b0)) begin
        fails++; $display("FAIL rr_bubble r%0d: grant %b busy0 %b exp 00000 0", r, grant, out_busy[0]);
      end
      @(negedge clk);
      req[order[r]] = 1'b1;
    end
    req = '0;
    @(posedge clk); #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL rr_drain: got %b exp %b", grant, 5'b0); end
  endtask

  task automatic test_parallel;
    @(negedge clk);
    req = 5'b11111;
    for (int i = 0; i < 5; i++) set_dest(i, 3'(4 - i));
    @(posedge clk); #1;
    tests++; if (grant !== 5'b11111) begin fails++; $display("FAIL par_grant: got %b exp %b", grant, 5'b11111); end
    tests++; if (out_busy !== 5'b11111) begin fails++; $display("FAIL par_busy: got %b exp %b", out_busy, 5'b11111); end
    tests++; if (xbar_sel !== 15'b000_001_010_011_100) begin fails++; $display("FAIL par_xbar: got %b exp %b", xbar_sel, 15'b000_001_010_011_100); end
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL par_release: got %b exp %b", grant, 5'b0); end
    tests++; if (xbar_sel !== 15'b000_001_010_011_100) begin fails++; $display("FAIL par_xbar_hold: got %b exp %b", xbar_sel, 15'b000_001_010_011_100); end
  endtask

  task automatic test_wormhole;
    @(negedge clk);
    req[2] = 1'b1; set_dest(2, 3'd1);
    @(posedge clk); #1;
    tests++; if (grant !== 5'b00100) begin fails++; $display("FAIL worm_grant: got %b exp %b", grant, 5'b00100); end
    @(negedge clk);
    set_dest(2, 3'd3);
    req[0] = 1'b1; set_dest(0, 3'd1);
    repeat (2) begin
      @(posedge clk); #1;
      tests++; if (grant !== 5'b00100) begin fails++; $display("FAIL worm_locked: got %b exp %b", grant, 5'b00100); end
      tests++; if (xbar_sel[5:3] !== 3'd2) begin fails++; $display("FAIL worm_xbar: got %0d exp 2", xbar_sel[5:3]); end
      tests++; if (out_busy !== 5'b00010) begin fails++; $display("FAIL worm_busy: got %b exp %b", out_busy, 5'b00010); end
    end
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk); #1;
    tests++; if ((grant !== 5'b0) || (out_busy !== 5'b0)) begin fails++; $display("FAIL worm_bubble: grant %b busy %b exp 00000 00000", grant, out_busy); end
    @(posedge clk); #1;
    tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL worm_next: got %b exp %b", grant, 5'b00001); end
    tests++; if (xbar_sel[5:3] !== 3'd0) begin fails++; $display("FAIL worm_next_xbar: got %0d exp 0", xbar_sel[5:3]); end
    @(negedge clk);
    req = '0;
    @(posedge clk);
  endtask

  task automatic test_invalid_dest;
    @(negedge clk);
    req[3] = 1'b1; set_dest(3, 3'd6);
    repeat (2) begin
      @(posedge clk); #1;
      tests++; if (grant !== 5'b0) begin fails++; $display("FAIL inv_grant: got %b exp %b", grant, 5'b0); end
      tests++; if (dest_err !== 5'b01000) begin fails++; $display("FAIL inv_err: got %b exp %b", dest_err, 5'b01000); end
    end
    @(negedge clk);
    set_dest(3, 3'd1);
    @(posedge clk); #1;
    tests++; if (dest_err !== 5'b0) begin fails++; $display("FAIL inv_err_clear: got %b exp %b", dest_err, 5'b0); end
    tests++; if (grant !== 5'b01000) begin fails++; $display("FAIL inv_fixed_grant: got %b exp %b", grant, 5'b01000); end
    @(negedge clk);
    req = '0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_packet;
    @(negedge clk);
    req[1] = 1'b1; set_dest(1, 3'd0);
    req[2] = 1'b1; set_dest(2, 3'd4);
    @(posedge clk); #1;
    tests++; if (grant !== 5'b00110) begin fails++; $display("FAIL mid_pre_grant: got %b exp %b", grant, 5'b00110); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (grant !== 5'b0) begin fails++; $display("FAIL mid_async_grant: got %b exp %b", grant, 5'b0); end
    tests++; if (out_busy !== 5'b0) begin fails++; $display("FAIL mid_async_busy: got %b exp %b", out_busy, 5'b0); end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b1; set_dest(0, 3'd4);
    req[3] = 1'b1; set_dest(3, 3'd4);
    @(posedge clk); #1;
    tests++; if (grant !== 5'b00001) begin fails++; $display("FAIL mid_fresh_ptr: got %b exp %b", grant, 5'b00001); end
    tests++; if (xbar_sel[14:12] !== 3'd0) begin fails++; $display("FAIL mid_fresh_xbar: got %0d exp 0", xbar_sel[14:12]); end
    @(negedge clk);
    req = '0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_parallel();
    test_wormhole();
    test_invalid_dest();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
